sde_trig_sequencer: RTL and testbench

Central trigger sequencer on the CLK120 domain, downstream of the per-PMT trigger modules (single-bin, 40 MHz-compatible ToT, ToTd, MoPS, external).
- Merges up to N_SRC one-cycle trigger pulses into a single event trigger, accumulating a source-type mask over a programmable coincidence window.
- Handshakes with the event buffer controller and enforces a programmable post-event holdoff.
- Counts accepted triggers, and triggers lost to dead time.

---
 rtl/sde_trig_sequencer.sv | 136 +++++++++++++
 tb/tb_sde_trig_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sde_trig_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sde_trig_sequencer
// Merges enabled trigger pulses into one event trigger, with holdoff and counters.
// Revision : 1.0
// ============================================================================
module sde_trig_sequencer #(
    parameter int N_SRC     = 8,
    parameter int WIN_SIZE  = 4,
    parameter int HOLD_SIZE = 16,
    parameter int CNT_SIZE  = 24
) (
    input  logic                 CLK120,
    input  logic                 RESET,
    input  logic [N_SRC-1:0]     TRIG_IN,
    input  logic [N_SRC-1:0]     SRC_ENABLE,
    input  logic [WIN_SIZE-1:0]  COLLECT_WIN,
    input  logic [HOLD_SIZE-1:0] HOLDOFF,
    input  logic                 BUF_AVAIL,
    input  logic                 EVT_ACK,
    input  logic                 CLR_COUNTS,
    output logic                 TRIG_OUT,
    output logic [N_SRC-1:0]     TRIG_TYPE,
    output logic                 BUSY,
    output logic [CNT_SIZE-1:0]  TRIG_COUNT,
    output logic [CNT_SIZE-1:0]  DEAD_COUNT
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_HOLDOFF  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [N_SRC-1:0]      r_acc;
    logic [WIN_SIZE-1:0]   r_wcnt;
    logic [HOLD_SIZE-1:0]  r_hcnt;
    logic                  r_trig_out;
    logic [N_SRC-1:0]      r_trig_type;
    logic                  r_busy;
    logic [CNT_SIZE-1:0]   r_trig_count;
    logic [CNT_SIZE-1:0]   r_dead_count;

    logic [N_SRC-1:0]      w_m;
    logic                  w_hit;
    logic                  w_accept;
    logic                  w_dead;

    assign w_m      = TRIG_IN & SRC_ENABLE;
    assign w_hit    = |w_m;
    assign w_accept = (r_state == S_COLLECT) && (r_wcnt == '0);
    // A rejected cycle counts once no matter how many sources fired.
    assign w_dead   = w_hit && (((r_state == S_IDLE) && !BUF_AVAIL) ||
                                (r_state == S_WAIT_ACK) || (r_state == S_HOLDOFF));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (w_hit && BUF_AVAIL) w_state_next = S_COLLECT;
            S_COLLECT:  if (r_wcnt == '0) w_state_next = S_WAIT_ACK;
            S_WAIT_ACK: if (EVT_ACK) w_state_next = (HOLDOFF == '0) ? S_IDLE : S_HOLDOFF;
            S_HOLDOFF:  if (r_hcnt == '0) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK120) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_wcnt       <= '0;
            r_hcnt       <= '0;
            r_trig_out   <= 1'b0;
            r_trig_type  <= '0;
            r_busy       <= 1'b0;
            r_trig_count <= '0;
            r_dead_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_trig_out <= w_accept;
            r_busy     <= (w_state_next != S_IDLE) || !BUF_AVAIL;

            case (r_state)
                S_IDLE: begin
                    if (w_hit && BUF_AVAIL) begin
                        r_acc  <= w_m;
                        r_wcnt <= COLLECT_WIN;
                    end
                end
                S_COLLECT: begin
                    r_acc <= r_acc | w_m;
                    if (r_wcnt != '0)
                        r_wcnt <= r_wcnt - 1'b1;
                    else
                        r_trig_type <= r_acc | w_m;
                end
                S_WAIT_ACK: begin
                    if (EVT_ACK) begin
                        if (HOLDOFF == '0)
                            r_trig_type <= '0;
                        else
                            r_hcnt <= HOLDOFF - 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (r_hcnt == '0)
                        r_trig_type <= '0;
                    else
                        r_hcnt <= r_hcnt - 1'b1;
                end
                default: ;
            endcase

            if (CLR_COUNTS) begin
                r_trig_count <= '0;
                r_dead_count <= '0;
            end else begin
                if (w_accept && (r_trig_count != '1))
                    r_trig_count <= r_trig_count + 1'b1;
                if (w_dead && (r_dead_count != '1))
                    r_dead_count <= r_dead_count + 1'b1;
            end
        end
    end

    assign TRIG_OUT   = r_trig_out;
    assign TRIG_TYPE  = r_trig_type;
    assign BUSY       = r_busy;
    assign TRIG_COUNT = r_trig_count;
    assign DEAD_COUNT = r_dead_count;

endmodule
`default_nettype wire

// File: tb/tb_sde_trig_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sde_trig_sequencer
// Directed bench for sde_trig_sequencer; trigger types are checked against a queue.
// Revision : 1.0
// ============================================================================
module tb_sde_trig_sequencer;

    localparam int N_SRC     = 8;
    localparam int WIN_SIZE  = 4;
    localparam int HOLD_SIZE = 16;
    localparam int CNT_SIZE  = 4;

    logic                 CLK120 = 1'b0;
    logic                 RESET = 1'b1;
    logic [N_SRC-1:0]     TRIG_IN = '0;
    logic [N_SRC-1:0]     SRC_ENABLE = '1;
    logic [WIN_SIZE-1:0]  COLLECT_WIN = '0;
    logic [HOLD_SIZE-1:0] HOLDOFF = '0;
    logic                 BUF_AVAIL = 1'b1;
    logic                 EVT_ACK = 1'b0;
    logic                 CLR_COUNTS = 1'b0;
    logic                 TRIG_OUT;
    logic [N_SRC-1:0]     TRIG_TYPE;
    logic                 BUSY;
    logic [CNT_SIZE-1:0]  TRIG_COUNT;
    logic [CNT_SIZE-1:0]  DEAD_COUNT;

    int total = 0;
    int bad   = 0;
    logic [N_SRC-1:0] exp_q[$];

    sde_trig_sequencer #(
        .N_SRC(N_SRC), .WIN_SIZE(WIN_SIZE), .HOLD_SIZE(HOLD_SIZE), .CNT_SIZE(CNT_SIZE)
    ) dut (
        .CLK120(CLK120), .RESET(RESET), .TRIG_IN(TRIG_IN), .SRC_ENABLE(SRC_ENABLE),
        .COLLECT_WIN(COLLECT_WIN), .HOLDOFF(HOLDOFF), .BUF_AVAIL(BUF_AVAIL),
        .EVT_ACK(EVT_ACK), .CLR_COUNTS(CLR_COUNTS), .TRIG_OUT(TRIG_OUT),
        .TRIG_TYPE(TRIG_TYPE), .BUSY(BUSY), .TRIG_COUNT(TRIG_COUNT), .DEAD_COUNT(DEAD_COUNT)
    );

    always #5 CLK120 = ~CLK120;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK120);
        #1;
    endtask

    // Every trigger pulse must match the oldest expected type.
    always @(negedge CLK120) begin
        if (!RESET && TRIG_OUT === 1'b1) begin
            chk("sb_pending", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0)
                chk("sb_trig_type", {24'd0, TRIG_TYPE}, {24'd0, exp_q.pop_front()});
        end
    end

    initial begin
        // Reset state
        tick(2);
        RESET = 1'b0;
        tick(1);
        chk("rst_trig_out", {31'd0, TRIG_OUT}, 32'd0);
        chk("rst_trig_type", {24'd0, TRIG_TYPE}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_trig_count", {28'd0, TRIG_COUNT}, 32'd0);
        chk("rst_dead_count", {28'd0, DEAD_COUNT}, 32'd0);

        // Single source, no window, no holdoff
        TRIG_IN = 8'h02; exp_q.push_back(8'h02);
        tick(1);
        TRIG_IN = 8'h00;
        chk("t1_no_trig_k", {31'd0, TRIG_OUT}, 32'd0);
        chk("t1_busy_k", {31'd0, BUSY}, 32'd1);
        tick(1);
        chk("t1_trig_k1", {31'd0, TRIG_OUT}, 32'd1);
        chk("t1_type", {24'd0, TRIG_TYPE}, 32'h02);
        chk("t1_count", {28'd0, TRIG_COUNT}, 32'd1);
        tick(1);
        chk("t1_trig_one_cycle", {31'd0, TRIG_OUT}, 32'd0);
        chk("t1_type_held", {24'd0, TRIG_TYPE}, 32'h02);
        tick(1);
        EVT_ACK = 1'b1;
        tick(1);
        EVT_ACK = 1'b0;
        chk("t1_type_cleared", {24'd0, TRIG_TYPE}, 32'h00);
        chk("t1_busy_after_ack", {31'd0, BUSY}, 32'd0);
        chk("t1_dead", {28'd0, DEAD_COUNT}, 32'd0);

        // Coincidence window of 3, with a late pulse landing in WAIT_ACK
        CLR_COUNTS = 1'b1; tick(1); CLR_COUNTS = 1'b0;
        COLLECT_WIN = 4'd3;
        TRIG_IN = 8'h01; exp_q.push_back(8'h05);
        tick(1);
        TRIG_IN = 8'h00;
        COLLECT_WIN = 4'd15;
        tick(2);
        TRIG_IN = 8'h04;
        tick(1);
        TRIG_IN = 8'h00;
        chk("t2_no_trig_k3", {31'd0, TRIG_OUT}, 32'd0);
        tick(1);
        chk("t2_trig_k4", {31'd0, TRIG_OUT}, 32'd1);
        chk("t2_type", {24'd0, TRIG_TYPE}, 32'h05);
        TRIG_IN = 8'h10;
        tick(1);
        TRIG_IN = 8'h00;
        chk("t2_dead_wait_ack", {28'd0, DEAD_COUNT}, 32'd1);

        // Holdoff of 5 with a pulse on every cycle after the ack
        HOLDOFF = 16'd5;
        COLLECT_WIN = 4'd0;
        EVT_ACK = 1'b1;
        tick(1);
        EVT_ACK = 1'b0;
        TRIG_IN = 8'h01;
        tick(4);
        chk("t3_busy_holdoff", {31'd0, BUSY}, 32'd1);
        chk("t3_type_held_holdoff", {24'd0, TRIG_TYPE}, 32'h05);
        chk("t3_dead_a4", {28'd0, DEAD_COUNT}, 32'd5);
        tick(1);
        chk("t3_dead_a5", {28'd0, DEAD_COUNT}, 32'd6);
        chk("t3_busy_low_a6", {31'd0, BUSY}, 32'd0);
        chk("t3_type_cleared", {24'd0, TRIG_TYPE}, 32'h00);
        exp_q.push_back(8'h01);
        tick(1);
        TRIG_IN = 8'h00;
        chk("t3_rearm_busy", {31'd0, BUSY}, 32'd1);
        chk("t3_dead_stable", {28'd0, DEAD_COUNT}, 32'd6);
        tick(1);
        chk("t3_trig_new", {31'd0, TRIG_OUT}, 32'd1);
        chk("t3_count", {28'd0, TRIG_COUNT}, 32'd2);
        HOLDOFF = 16'd0;
        EVT_ACK = 1'b1;
        tick(1);
        EVT_ACK = 1'b0;

        // No buffer available: dead counting, masking, saturation, clear priority
        CLR_COUNTS = 1'b1; tick(1); CLR_COUNTS = 1'b0;
        BUF_AVAIL = 1'b0;
        SRC_ENABLE = 8'h0F;
        TRIG_IN = 8'hFF;
        tick(10);
        chk("t4_dead10", {28'd0, DEAD_COUNT}, 32'd10);
        chk("t4_no_accept", {28'd0, TRIG_COUNT}, 32'd0);
        chk("t4_busy", {31'd0, BUSY}, 32'd1);
        SRC_ENABLE = 8'h00;
        tick(5);
        chk("t4_masked", {28'd0, DEAD_COUNT}, 32'd10);
        SRC_ENABLE = 8'h0F;
        tick(6);
        chk("t4_saturate", {28'd0, DEAD_COUNT}, 32'd15);
        CLR_COUNTS = 1'b1;
        tick(1);
        CLR_COUNTS = 1'b0;
        chk("t4_clr_wins", {28'd0, DEAD_COUNT}, 32'd0);
        TRIG_IN = 8'h00;
        SRC_ENABLE = 8'hFF;
        BUF_AVAIL = 1'b1;
        tick(1);

        // Reset in the middle of a long window
        COLLECT_WIN = 4'd8;
        TRIG_IN = 8'h01;
        tick(1);
        TRIG_IN = 8'h00;
        tick(2);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        chk("t5_trig_out", {31'd0, TRIG_OUT}, 32'd0);
        chk("t5_type", {24'd0, TRIG_TYPE}, 32'h00);
        chk("t5_busy", {31'd0, BUSY}, 32'd0);
        chk("t5_counts", {24'd0, TRIG_COUNT, DEAD_COUNT}, 32'd0);
        tick(10);
        EVT_ACK = 1'b1;
        tick(1);
        EVT_ACK = 1'b0;
        chk("t5_ack_ignored_busy", {31'd0, BUSY}, 32'd0);
        chk("t5_ack_ignored_type", {24'd0, TRIG_TYPE}, 32'h00);
        COLLECT_WIN = 4'd0;
        TRIG_IN = 8'h08; exp_q.push_back(8'h08);
        tick(1);
        TRIG_IN = 8'h00;
        tick(1);
        chk("t5_next_trig", {31'd0, TRIG_OUT}, 32'd1);
        chk("t5_next_type", {24'd0, TRIG_TYPE}, 32'h08);
        chk("t5_next_count", {28'd0, TRIG_COUNT}, 32'd1);
        EVT_ACK = 1'b1;
        tick(1);
        EVT_ACK = 1'b0;
        tick(3);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
